wb_queue: RTL
=============

// Module: wb_queue
// PURPOSE
//  Write-back queue between the execution stage and the reg_file write port.
//  Buffers completed results as (register index, data) pairs in a small FIFO.
//  Drains at most one result per cycle into the single reg_file write port.
//  Forwards still-pending results onto the two read paths, so readers never
//  see stale register contents.
// PARAMETERS
//  WIDTH   16  data width; must match reg_file WIDTH
//  DEPTH   8   register count; must match reg_file DEPTH; AW = $clog2(DEPTH)
//  QDEPTH  4   queue entries; power of 2, >= 2; QW = $clog2(QDEPTH)
// PORTS
//  clk            in   1      clock; all state updates on the active edge
//  rst            in   1      synchronous, active-high reset
//  in_valid       in   1      producer offers a result
//  in_ready       out  1      queue accepts the result this cycle
//  in_reg         in   AW     destination register index
//  in_data        in   WIDTH  result data
//  drain_en       in   1      1 = allow pop to reg_file; 0 = hold queue
//  rf_we          out  1      reg_file write enable
//  rf_write_reg   out  AW     reg_file write index (head entry)
//  rf_write_data  out  WIDTH  reg_file write data (head entry)
//  rd_reg1        in   AW     read index, port 1 (same value driven to reg_file)
//  rd_reg2        in   AW     read index, port 2
//  rf_rd_data1    in   WIDTH  raw reg_file read_out_1
//  rf_rd_data2    in   WIDTH  raw reg_file read_out_2
//  rd_data1       out  WIDTH  forwarded read data, port 1
//  rd_data2       out  WIDTH  forwarded read data, port 2
//  count          out  QW+1   occupied entries, 0..QDEPTH
//  empty, full    out  1      count==0 / count==QDEPTH
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - wr_ptr=0, rd_ptr=0, count=0, all slot valid bits cleared.
//    - Slot data is not cleared.
//    - After reset: empty=1, full=0, in_ready=1, rf_we=0.
//  - While rst=1: in_ready=0 and rf_we=0 combinationally.
//    - Pending entries are discarded and never written.
//  - Push = in_valid & in_ready.
//    - in_ready = ~full & ~rst. It does not depend on a same-cycle pop.
//    - Slot[wr_ptr] <= {in_reg,in_data}, valid set, wr_ptr <= wr_ptr+1 mod QDEPTH.
//  - Pop = rf_we = ~empty & drain_en & ~rst.
//    - rf_write_reg/rf_write_data are driven combinationally from slot[rd_ptr].
//    - At the edge: valid cleared, rd_ptr <= rd_ptr+1 mod QDEPTH.
//    - When empty, rf_write_reg/rf_write_data are don't-care; rf_we=0.
//  - count: push only +1; pop only -1; push & pop together unchanged.
//    - Writes drain in strict FIFO order.
//  - Latency: a result pushed into an empty queue appears on rf_we the next
//    cycle, provided drain_en=1.
//  - Forwarding (combinational):
//    - rd_dataN = data of the youngest valid slot with reg == rd_regN.
//    - Youngest = closest behind wr_ptr. The head slot being popped this
//      cycle counts as valid.
//    - No match: rd_dataN = rf_rd_dataN.
//    - in_data of a same-cycle push is not forwarded.
//  - Pointer wrap is modulo QDEPTH. full and empty are derived from count,
//    not from pointer equality.
// TESTING
//  T1 rst, then push r3=16'h1234 with drain_en=1
//     -> next cycle rf_we=1, rf_write_reg=3, rf_write_data=16'h1234;
//        the following cycle empty=1, count=0.
//  T2 drain_en=0, push r1..r4 = 16'h0001..16'h0004
//     -> full=1, count=4, in_ready=0; a 5th push is ignored.
//     -> drain_en=1: rf_we high for 4 cycles, order r1..r4.
//  T3 drain_en=0, push r2=16'h0011 then r2=16'h0022; rd_reg1=2,
//     rf_rd_data1=16'hAAAA, rd_reg2=5, rf_rd_data2=16'h5555
//     -> rd_data1=16'h0022, rd_data2=16'h5555.
//  T4 count=2, push and pop in the same cycle for 10 cycles
//     -> count stays 2; pointers wrap; reg_file receives data in push order.
//  T5 rst=1 with 3 entries pending
//     -> rf_we=0 during rst; after rst empty=1, rf_we stays 0;
//        rd_dataN = rf_rd_dataN.
//  T6 full=1 with drain_en=1 and in_valid=1
//     -> in_ready=0 that cycle; next cycle count=3, in_ready=1.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue
// Write-back queue sitting between the execution stage and the single
// reg_file write port. Completed results are buffered as (register, data)
// pairs in a small FIFO and drained in order, one per cycle, whenever
// drain_en allows. Results still waiting in the queue are forwarded onto
// both read paths, so readers never observe stale register contents.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         producer handshake for a new result
//   in_reg, in_data           destination register index and result data
//   drain_en                  permits popping the head into the reg_file
//   rf_we, rf_write_reg/data  reg_file write port, driven from the head slot
//   rd_reg1/2                 read indices (also driven to the reg_file)
//   rf_rd_data1/2             raw reg_file read data
//   rd_data1/2                read data after forwarding from the queue
//   count, empty, full        occupancy status
module wb_queue #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int QDEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int QW    = $clog2(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_reg,
  input  logic [WIDTH-1:0] in_data,
  input  logic             drain_en,
  output logic             rf_we,
  output logic [AW-1:0]    rf_write_reg,
  output logic [WIDTH-1:0] rf_write_data,
  input  logic [AW-1:0]    rd_reg1,
  input  logic [AW-1:0]    rd_reg2,
  input  logic [WIDTH-1:0] rf_rd_data1,
  input  logic [WIDTH-1:0] rf_rd_data2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic [QW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [AW-1:0]    slot_reg_q  [QDEPTH];
  logic [WIDTH-1:0] slot_data_q [QDEPTH];
  logic [QDEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [QW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [QW:0]       count_q, count_d;
  logic              push, pop;

  // Occupancy comes from the counter: pointer equality is ambiguous
  // between completely full and completely empty.
  assign empty = (count_q == '0);
  assign full  = (count_q == (QW+1)'(QDEPTH));
  assign count = count_q;

  // in_ready deliberately ignores a same-cycle pop to keep the
  // producer handshake free of a path through drain_en.
  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & drain_en & ~rst;

  assign rf_we         = pop;
  assign rf_write_reg  = slot_reg_q[rd_ptr_q];
  assign rf_write_data = slot_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    slot_vld_d = slot_vld_q;
    // QDEPTH is a power of two, so pointer overflow wraps naturally.
    if (push) begin
      wr_ptr_d             = wr_ptr_q + QW'(1);
      slot_vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + QW'(1);
      // push and pop never target the same slot: a full queue refuses
      // pushes and an empty queue never pops.
      slot_vld_d[rd_ptr_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (QW+1)'(1);
      2'b01:   count_d = count_q - (QW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      slot_vld_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  // Slot payload carries no reset; the valid bits alone say what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_reg_q[wr_ptr_q]  <= in_reg;
      slot_data_q[wr_ptr_q] <= in_data;
    end
  end

  // Forwarding, one instance per read port.
  logic [1:0][AW-1:0]    fwd_reg;
  logic [1:0][WIDTH-1:0] fwd_raw;
  logic [1:0][WIDTH-1:0] fwd_out;

  assign fwd_reg[0] = rd_reg1;
  assign fwd_reg[1] = rd_reg2;
  assign fwd_raw[0] = rf_rd_data1;
  assign fwd_raw[1] = rf_rd_data2;
  assign rd_data1   = fwd_out[0];
  assign rd_data2   = fwd_out[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [WIDTH-1:0] sel_data;
      logic [QW-1:0]    idx;
      // Walk from oldest (wr_ptr - QDEPTH) to youngest (wr_ptr - 1) so a
      // later match overrides an earlier one. The head slot being popped
      // this cycle is still valid here, which covers the write that the
      // reg_file has not yet absorbed.
      always_comb begin
        sel_data = fwd_raw[gi];
        idx      = '0;
        for (int k = QDEPTH; k >= 1; k--) begin
          idx = wr_ptr_q - QW'(k);
          if (slot_vld_q[idx] && (slot_reg_q[idx] == fwd_reg[gi])) begin
            sel_data = slot_data_q[idx];
          end
        end
      end
      assign fwd_out[gi] = sel_data;
    end
  endgenerate

endmodule
